// File: rtl/vend_pkg.sv
// Shared types for the vending controller: FSM state encoding and coin codes.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } vend_state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_LO   = 2'b01;
   localparam logic [1:0] COIN_HI   = 2'b10;
   localparam logic [1:0] COIN_BAD  = 2'b11;

endpackage

// File: rtl/vend_ctrl.sv
// Vending controller: credit accumulation, held dispense request, unit-by-unit refund.
// Optional VEND_CHANGE_EN enables the CHANGE state and cancel refunds; otherwise leftover credit carries over.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int PRICE_UNITS   = 3,
   parameter int COIN_HI_UNITS = 2,
   localparam int CREDIT_W     = $clog2(PRICE_UNITS + COIN_HI_UNITS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                take,
   output logic                dispense,
   output logic                change_pulse,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit
);

   localparam logic [CREDIT_W-1:0] PRICE_U = CREDIT_W'(PRICE_UNITS);
   localparam logic [CREDIT_W-1:0] HI_U    = CREDIT_W'(COIN_HI_UNITS);
   localparam logic [CREDIT_W-1:0] ONE_U   = CREDIT_W'(1);

   vend_state_t         r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic                r_coin_reject;

   logic [CREDIT_W-1:0] w_coin_units;
   logic [CREDIT_W-1:0] w_credit_sum;
   logic [CREDIT_W-1:0] w_credit_rem;
   logic                w_cancel;

   assign w_coin_units = (coin == COIN_HI) ? HI_U : ONE_U;
   assign w_credit_sum = r_credit + w_coin_units;
   assign w_credit_rem = r_credit - PRICE_U;

`ifdef VEND_CHANGE_EN
   assign w_cancel = cancel && (r_state == COLLECT);
`else
   assign w_cancel = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_credit      <= '0;
         r_coin_reject <= 1'b0;
      end else begin
         r_coin_reject <= 1'b0;
         case (r_state)
            IDLE, COLLECT: begin
               if (w_cancel) begin
                  // cancel wins: any coin arriving alongside is handed back
                  r_state       <= CHANGE;
                  r_coin_reject <= (coin != COIN_NONE);
               end else if (coin == COIN_BAD) begin
                  r_coin_reject <= 1'b1;
               end else if (coin != COIN_NONE) begin
                  r_credit <= w_credit_sum;
                  r_state  <= (w_credit_sum >= PRICE_U) ? DISPENSE : COLLECT;
               end
            end
            DISPENSE: begin
               r_coin_reject <= (coin != COIN_NONE);
               if (take) begin
                  r_credit <= w_credit_rem;
`ifdef VEND_CHANGE_EN
                  r_state  <= (w_credit_rem != '0) ? CHANGE : IDLE;
`else
                  // a high coin worth more than the price can leave enough for another item
                  if (w_credit_rem >= PRICE_U)
                     r_state <= DISPENSE;
                  else
                     r_state <= (w_credit_rem != '0) ? COLLECT : IDLE;
`endif
               end
            end
`ifdef VEND_CHANGE_EN
            CHANGE: begin
               r_coin_reject <= (coin != COIN_NONE);
               if (r_credit <= ONE_U) begin
                  r_credit <= '0;
                  r_state  <= IDLE;
               end else begin
                  r_credit <= r_credit - ONE_U;
               end
            end
`endif
            default: begin
               r_state  <= IDLE;
               r_credit <= '0;
            end
         endcase
      end
   end

   assign dispense    = (r_state == DISPENSE);
`ifdef VEND_CHANGE_EN
   assign change_pulse = (r_state == CHANGE);
`else
   assign change_pulse = 1'b0;
`endif
   assign coin_reject = r_coin_reject;
   assign credit      = r_credit;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl (PRICE_UNITS=3, COIN_HI_UNITS=2); expectations follow VEND_CHANGE_EN.
module tb_vend_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] coin;
   logic       cancel;
   logic       take;
   logic       dispense;
   logic       change_pulse;
   logic       coin_reject;
   logic [2:0] credit;

   int errors = 0;
   int checks = 0;

   vend_ctrl #(.PRICE_UNITS(3), .COIN_HI_UNITS(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .coin         (coin),
      .cancel       (cancel),
      .take         (take),
      .dispense     (dispense),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .credit       (credit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      coin = 2'b00; cancel = 1'b0; take = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; coin = 2'b11; cancel = 1'b0; take = 1'b0;
      tick();
      tick();
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit); end
      checks++; if (dispense !== 1'b0) begin errors++; $display("FAIL reset_dispense: got %b want 0", dispense); end
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL reset_change: got %b want 0", change_pulse); end
      checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b want 0", coin_reject); end
      rst = 1'b0; coin = 2'b00;
      tick();
   endtask

   task automatic test_exact_price();
      int pulses;
      do_reset();
      coin = 2'b01; tick();
      checks++; if (credit !== 3'd1) begin errors++; $display("FAIL exact_c1: got %0d want 1", credit); end
      checks++; if (dispense !== 1'b0) begin errors++; $display("FAIL exact_nodisp1: got %b want 0", dispense); end
      // take outside DISPENSE has no effect
      take = 1'b1; tick(); take = 1'b0;
      checks++; if (credit !== 3'd2) begin errors++; $display("FAIL exact_c2: got %0d want 2", credit); end
      tick();
      checks++; if (credit !== 3'd3) begin errors++; $display("FAIL exact_c3: got %0d want 3", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL exact_disp: got %b want 1", dispense); end
      coin = 2'b00; tick();
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL exact_disp_held: got %b want 1", dispense); end
      take = 1'b1; tick(); take = 1'b0;
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL exact_after_take: got %0d want 0", credit); end
      checks++; if (dispense !== 1'b0) begin errors++; $display("FAIL exact_disp_off: got %b want 0", dispense); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (change_pulse === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL exact_pulses: got %0d want 0", pulses); end
   endtask

   task automatic test_overpay();
      int pulses;
      do_reset();
      coin = 2'b10; tick();
      checks++; if (credit !== 3'd2) begin errors++; $display("FAIL over_c2: got %0d want 2", credit); end
      tick(); coin = 2'b00;
      checks++; if (credit !== 3'd4) begin errors++; $display("FAIL over_c4: got %0d want 4", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL over_disp: got %b want 1", dispense); end
      take = 1'b1; tick(); take = 1'b0;
      checks++; if (credit !== 3'd1) begin errors++; $display("FAIL over_rem: got %0d want 1", credit); end
      checks++; if (dispense !== 1'b0) begin errors++; $display("FAIL over_disp_off: got %b want 0", dispense); end
`ifdef VEND_CHANGE_EN
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         if (change_pulse === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses !== 1) begin errors++; $display("FAIL over_pulses: got %0d want 1", pulses); end
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL over_final: got %0d want 0", credit); end
`else
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL over_nochange: got %b want 0", change_pulse); end
      tick();
      checks++; if (credit !== 3'd1) begin errors++; $display("FAIL over_carry_held: got %0d want 1", credit); end
      coin = 2'b10; tick(); coin = 2'b00;
      checks++; if (credit !== 3'd3) begin errors++; $display("FAIL over_carry_c3: got %0d want 3", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL over_carry_disp: got %b want 1", dispense); end
      take = 1'b1; tick(); take = 1'b0;
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL over_carry_final: got %0d want 0", credit); end
`endif
   endtask

   task automatic test_cancel();
      int pulses;
      do_reset();
      coin = 2'b10; tick();
      checks++; if (credit !== 3'd2) begin errors++; $display("FAIL cancel_c2: got %0d want 2", credit); end
      coin = 2'b01; cancel = 1'b1; tick(); coin = 2'b00; cancel = 1'b0;
`ifdef VEND_CHANGE_EN
      checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL cancel_reject: got %b want 1", coin_reject); end
      checks++; if (credit !== 3'd2) begin errors++; $display("FAIL cancel_credit: got %0d want 2", credit); end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         if (change_pulse === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses !== 2) begin errors++; $display("FAIL cancel_pulses: got %0d want 2", pulses); end
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL cancel_final: got %0d want 0", credit); end
      checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL cancel_reject_clr: got %b want 0", coin_reject); end
`else
      pulses = 0;
      checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL cancel_ign_reject: got %b want 0", coin_reject); end
      checks++; if (credit !== 3'd3) begin errors++; $display("FAIL cancel_ign_credit: got %0d want 3", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL cancel_ign_disp: got %b want 1", dispense); end
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL cancel_ign_change: got %b want 0", change_pulse); end
      take = 1'b1; tick(); take = 1'b0;
`endif
   endtask

   task automatic test_reject();
      do_reset();
      coin = 2'b11; tick(); coin = 2'b00;
      checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL rej_bad_pulse: got %b want 1", coin_reject); end
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL rej_bad_credit: got %0d want 0", credit); end
      tick();
      checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL rej_bad_clr: got %b want 0", coin_reject); end
      coin = 2'b10; tick();
      coin = 2'b01; tick();
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL rej_disp: got %b want 1", dispense); end
      tick(); coin = 2'b00;
      checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL rej_disp_pulse: got %b want 1", coin_reject); end
      checks++; if (credit !== 3'd3) begin errors++; $display("FAIL rej_disp_credit: got %0d want 3", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL rej_disp_state: got %b want 1", dispense); end
      cancel = 1'b1; tick(); cancel = 1'b0;
      checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL rej_disp_clr: got %b want 0", coin_reject); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL rej_cancel_ign: got %b want 1", dispense); end
      take = 1'b1; tick(); take = 1'b0;
      // back-to-back purchase straight after returning to IDLE
      coin = 2'b10; tick();
      coin = 2'b10; tick(); coin = 2'b00;
      checks++; if (credit !== 3'd4) begin errors++; $display("FAIL b2b_c4: got %0d want 4", credit); end
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL b2b_disp: got %b want 1", dispense); end
   endtask

   task automatic test_reset_mid_flight();
      int pulses;
      do_reset();
      coin = 2'b10; tick();
      tick(); coin = 2'b00;
      take = 1'b1; tick(); take = 1'b0;
`ifdef VEND_CHANGE_EN
      checks++; if (change_pulse !== 1'b1) begin errors++; $display("FAIL rmid_in_change: got %b want 1", change_pulse); end
`else
      checks++; if (credit !== 3'd1) begin errors++; $display("FAIL rmid_carry: got %0d want 1", credit); end
`endif
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL rmid_credit: got %0d want 0", credit); end
      checks++; if (change_pulse !== 1'b0) begin errors++; $display("FAIL rmid_change: got %b want 0", change_pulse); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (change_pulse === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_pulses: got %0d want 0", pulses); end
      coin = 2'b01; tick(); coin = 2'b00;
      checks++; if (credit !== 3'd1) begin errors++; $display("FAIL rmid_fresh: got %0d want 1", credit); end
      coin = 2'b10; tick(); coin = 2'b00;
      checks++; if (dispense !== 1'b1) begin errors++; $display("FAIL rmid_disp: got %b want 1", dispense); end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (dispense !== 1'b0) begin errors++; $display("FAIL rdisp_off: got %b want 0", dispense); end
      checks++; if (credit !== 3'd0) begin errors++; $display("FAIL rdisp_credit: got %0d want 0", credit); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_exact_price();
      test_overpay();
      test_cancel();
      test_reject();
      test_reset_mid_flight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
